// File: rtl/c64_mem_pkg.sv
// c64_mem_pkg: shared types and address-range constants for the C64 memory map.
//   state_t  - bus FSM states
//   region_t - decoded target of a core access
package c64_mem_pkg;

    localparam int unsigned AB_W = 16;
    localparam int unsigned MA_W = 17;
    localparam int unsigned DW   = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        REG_PORT   = 3'd0,
        REG_IO     = 3'd1,
        REG_RAM    = 3'd2,
        REG_BASIC  = 3'd3,
        REG_KERNAL = 3'd4,
        REG_CHAR   = 3'd5
    } region_t;

    // Upper address bits identifying each banked window
    localparam logic [14:0] PORT_PAGE   = 15'h0000;  // $0000-$0001
    localparam logic [2:0]  BASIC_PAGE  = 3'b101;    // $A000-$BFFF
    localparam logic [2:0]  KERNAL_PAGE = 3'b111;    // $E000-$FFFF
    localparam logic [3:0]  IO_PAGE     = 4'hD;      // $D000-$DFFF

endpackage

// File: rtl/c64_bank_decode.sv
// c64_bank_decode: combinational C64 banking decode.
//   ab       - core address
//   we       - core write enable (writes never target ROM)
//   eff      - effective LORAM/HIRAM/CHAREN bits {CHAREN, HIRAM, LORAM}
//   region   - decoded target
//   mem_addr - external address (bit16 = ROM space); meaningful for RAM/ROM regions
module c64_bank_decode
    import c64_mem_pkg::*;
#(
    parameter logic [16:0] BASIC_BASE  = 17'h10000,
    parameter logic [16:0] KERNAL_BASE = 17'h12000,
    parameter logic [16:0] CHAR_BASE   = 17'h14000
) (
    input  logic [15:0] ab,
    input  logic        we,
    input  logic [2:0]  eff,
    output region_t     region,
    output logic [16:0] mem_addr
);

    logic loram;
    logic hiram;
    logic charen;
    logic in_port;
    logic in_basic;
    logic in_kernal;
    logic in_d;

    assign loram     = eff[0];
    assign hiram     = eff[1];
    assign charen    = eff[2];
    assign in_port   = (ab[15:1] == PORT_PAGE);
    assign in_basic  = (ab[15:13] == BASIC_PAGE) && loram && hiram;
    assign in_kernal = (ab[15:13] == KERNAL_PAGE) && hiram;
    assign in_d      = (ab[15:12] == IO_PAGE) && (loram || hiram);

    // Windows are disjoint; ROM windows only apply to reads, I/O applies to both
    always_comb begin
        region   = REG_RAM;
        mem_addr = {1'b0, ab};
        if (in_port) begin
            region = REG_PORT;
        end else if (in_d && charen) begin
            region = REG_IO;
        end else if (!we) begin
            if (in_basic) begin
                region   = REG_BASIC;
                mem_addr = BASIC_BASE + 17'(ab[12:0]);
            end else if (in_kernal) begin
                region   = REG_KERNAL;
                mem_addr = KERNAL_BASE + 17'(ab[12:0]);
            end else if (in_d) begin
                region   = REG_CHAR;
                mem_addr = CHAR_BASE + 17'(ab[11:0]);
            end
        end
    end

endmodule

// File: rtl/c64_mem_map.sv
// c64_mem_map: memory-map / bus-interface stage behind the 6502 core.
//   clk, reset             - clock, synchronous active-high reset
//   cpu_ab/cpu_do/cpu_we   - core access (accepted every cycle while rdy=1)
//   cpu_di, rdy            - registered read data and core stall
//   io_cs, io_rdata        - I/O strobe (combinational, accept cycle) and read data
//   mem_*                  - external RAM/ROM req/ack port
//   bus_err                - sticky external timeout flag
module c64_mem_map
    import c64_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT     = 16,
    parameter logic [16:0] BASIC_BASE  = 17'h10000,
    parameter logic [16:0] KERNAL_BASE = 17'h12000,
    parameter logic [16:0] CHAR_BASE   = 17'h14000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_ab,
    input  logic [7:0]  cpu_do,
    input  logic        cpu_we,
    output logic [7:0]  cpu_di,
    output logic        rdy,
    output logic        io_cs,
    input  logic [7:0]  io_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [16:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic        bus_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       ddr;
    logic [7:0]       port;
    logic [7:0]       eff;
    region_t          region;
    logic [16:0]      dec_addr;

    // Undriven port pins (ddr bit = 0) read back as 1
    assign eff = (port & ddr) | ~ddr;

    c64_bank_decode #(
        .BASIC_BASE  (BASIC_BASE),
        .KERNAL_BASE (KERNAL_BASE),
        .CHAR_BASE   (CHAR_BASE)
    ) u_decode (
        .ab       (cpu_ab),
        .we       (cpu_we),
        .eff      (eff[2:0]),
        .region   (region),
        .mem_addr (dec_addr)
    );

    // I/O strobe lives in the accept cycle so io_rdata lands on the same edge
    assign io_cs = !reset && (state == ST_IDLE) && (region == REG_IO);

    // Bus FSM, timeout counter and processor-port registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            ddr       <= 8'h00;
            port      <= 8'h00;
            cpu_di    <= 8'h00;
            rdy       <= 1'b1;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'h00;
            bus_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    case (region)
                        REG_PORT: begin
                            if (cpu_we) begin
                                if (cpu_ab[0]) port <= cpu_do;
                                else           ddr  <= cpu_do;
                            end else begin
                                cpu_di <= cpu_ab[0] ? eff : ddr;
                            end
                        end
                        REG_IO: begin
                            if (!cpu_we) cpu_di <= io_rdata;
                        end
                        default: begin
                            mem_req   <= 1'b1;
                            mem_we    <= cpu_we;
                            mem_addr  <= dec_addr;
                            mem_wdata <= cpu_do;
                            rdy       <= 1'b0;
                            cnt       <= '0;
                            state     <= ST_WAIT;
                        end
                    endcase
                end
                ST_WAIT: begin
                    // Ack takes priority over a coincident timeout
                    if (mem_ack) begin
                        if (!mem_we) cpu_di <= mem_rdata;
                        mem_req <= 1'b0;
                        rdy     <= 1'b1;
                        state   <= ST_IDLE;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        cpu_di  <= 8'hFF;
                        bus_err <= 1'b1;
                        mem_req <= 1'b0;
                        rdy     <= 1'b1;
                        state   <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
